// File: rtl/mips_pkg.sv
// Shared constants for the multi-cycle MIPS control path: opcodes,
// controller state codes, ALU operation codes and mux select codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_JR    = 6'b000110;

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEM_ADR = 4'd3,
    S_MEM_RD  = 4'd4,
    S_MEM_WB  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_R_EX    = 4'd7,
    S_R_WB    = 4'd8,
    S_ADDI_EX = 4'd9,
    S_SLTI_EX = 4'd10,
    S_I_WB    = 4'd11,
    S_BRANCH  = 4'd12,
    S_JUMP    = 4'd13,
    S_JAL     = 4'd14,
    S_JR      = 4'd15
  } state_e;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] ALUOP_SLT  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  localparam logic [1:0] ALUB_B     = 2'b00;
  localparam logic [1:0] ALUB_FOUR  = 2'b01;
  localparam logic [1:0] ALUB_IMM   = 2'b10;
  localparam logic [1:0] ALUB_IMMSH = 2'b11;

endpackage

// File: rtl/multicycle_controller.sv
// Moore-style control FSM for a shared-memory, single-ALU multi-cycle MIPS
// datapath (R-type, lw, sw, beq, addi, slti, j, jal, jr).
// Inputs : clk, rst_n (async, active low), opcode (IR[31:26]), zero (ALU
//          flag), mem_ready (memory finishes the current access this cycle).
// Outputs: datapath strobes/selects (pc_en, i_or_d, mem_read, mem_write,
//          ir_write, reg_dst, mem_to_reg, reg_write, link, alu_src_a,
//          alu_src_b, alu_op, pc_src), instr_done / illegal_op pulses and the
//          current state code for debug.
module multicycle_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       link,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_e state_q, state_d;
  logic   pc_write, pc_write_cond;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_RESET:   state_d = S_FETCH;
      S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_R_EX;
          OP_LW, OP_SW: state_d = S_MEM_ADR;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_SLTI:      state_d = S_SLTI_EX;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_JAL:       state_d = S_JAL;
          OP_JR:        state_d = S_JR;
          default:      state_d = S_FETCH;
        endcase
      end
      // IR is stable through the whole instruction, so the lw/sw split can
      // be taken here rather than carried from DECODE.
      S_MEM_ADR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:  state_d = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EX:    state_d = S_R_WB;
      S_ADDI_EX: state_d = S_I_WB;
      S_SLTI_EX: state_d = S_I_WB;
      default:   state_d = S_FETCH;
    endcase
  end

  // Output decode; only ir_write, pc_write and instr_done look at mem_ready.
  always_comb begin
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    link          = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUB_B;
    alu_op        = ALUOP_ADD;
    pc_src        = PCSRC_ALU;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALUB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = ALUB_IMMSH;
        case (opcode)
          OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_SLTI,
          OP_BEQ, OP_J, OP_JAL, OP_JR: ;
          default: begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_R_EX: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNC;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
      end
      S_SLTI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        alu_op    = ALUOP_SLT;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PCSRC_ALUOUT;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_src     = PCSRC_JUMP;
        reg_write  = 1'b1;
        link       = 1'b1;
        instr_done = 1'b1;
      end
      S_JR: begin
        pc_write   = 1'b1;
        pc_src     = PCSRC_REGA;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // zero only matters where pc_write_cond is raised, i.e. BRANCH.
  assign pc_en = pc_write | (pc_write_cond & zero);
  assign state = state_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style FSM that sequences a shared-memory, single-ALU multi-cycle MIPS datapath.
- Supports the same instruction subset as the single-cycle core: R-type, lw, sw, beq, addi, slti, j, jal, jr.
- Steps each instruction through fetch, decode, execute, memory and write-back.
- Stalls on memory through a ready handshake. The existing alu_controller consumes alu_op and func downstream.

Parameters:
- None. Opcodes and state codes are package constants.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_en  out  1  PC load enable = pc_write | (pc_write_cond & zero)
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- reg_dst  out  1  write register select: 1 = rd, 0 = rt
- mem_to_reg  out  1  write data select: 1 = MDR, 0 = ALUOut
- reg_write  out  1  register file write enable
- link  out  1  jal: write register 31 with PC
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = func field, 11 = slt
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction
- illegal_op  out  1  one-cycle pulse in DECODE on an unknown opcode
- state  out  4  current state code (debug)

Behaviour:
- Reset: rst_n low asynchronously forces state RESET. All outputs are 0 during and after reset until the first clk edge with rst_n high. RESET moves to FETCH unconditionally.
- Default: every output not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - While mem_ready is 0: stay in FETCH; ir_write and pc_write stay 0.
  - When mem_ready is 1: ir_write=1 and pc_write=1 in the same cycle (Mealy); go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target). Next state by opcode:
  - 000000 -> R_EX
  - 100011 (lw) or 101011 (sw) -> MEM_ADR
  - 001001 (addi) -> ADDI_EX
  - 001010 (slti) -> SLTI_EX
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 000011 (jal) -> JAL
  - 000110 (jr) -> JR
  - anything else: illegal_op=1, instr_done=1, go to FETCH
- MEM_ADR: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Go to FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready; in the ready cycle instr_done=1 and go to FETCH.
- R_EX: alu_src_a=1, alu_src_b=00, alu_op=10. Go to R_WB.
- R_WB: reg_write=1, reg_dst=1, instr_done=1. Go to FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Go to I_WB.
- SLTI_EX: alu_src_a=1, alu_src_b=10, alu_op=11. Go to I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01, instr_done=1. Go to FETCH.
- JUMP: pc_write=1, pc_src=10, instr_done=1. Go to FETCH.
- JAL: pc_write=1, pc_src=10, reg_write=1, link=1, instr_done=1. Go to FETCH.
- JR: pc_write=1, pc_src=11, instr_done=1. Go to FETCH.
- Latency with mem_ready tied high, FETCH to FETCH:
  - lw: 5 cycles
  - sw, R-type, addi, slti: 4 cycles
  - beq, j, jal, jr: 3 cycles
  - each mem_ready-low cycle adds 1 cycle
- pc_en: combinational; zero is only honoured in BRANCH.
- Reset mid-instruction: the in-flight instruction is abandoned. No write strobe may be asserted in the reset cycle or the following RESET cycle.
- Unreachable state codes: all outputs 0, next state FETCH.
- No glitch requirement on outputs. Outputs are decoded from registered state, except ir_write, pc_write and instr_done, which are gated by mem_ready.

Decomposition:
- Package mips_pkg holds:
  - opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI, OP_J, OP_JAL, OP_JR
  - the 4-bit state codes
  - ALUOP_ADD, ALUOP_SUB, ALUOP_FUNC, ALUOP_SLT
  - PCSRC_* and ALUB_* select codes
- No sub-module. One state register, a next-state block and an output-decode block.
- The existing alu_controller is instantiated by the datapath top, not inside this block.

Test Plan:
- Reset: rst_n=0 mid-MEM_RD with clk running -> state=RESET and all outputs 0 immediately. One cycle after release, state=FETCH and mem_read=1.
- lw (opcode 100011), mem_ready=1 -> state sequence FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB. MEM_WB has reg_write=1, mem_to_reg=1. instr_done pulses once at cycle 5.
- sw with mem_ready held low 3 cycles in MEM_WR -> mem_write=1 for 4 cycles, instr_done only in the ready cycle, no reg_write at any point.
- beq with zero=1, then repeated with zero=0 -> pc_en=1 in BRANCH with pc_src=01, then pc_en=0. Both take 3 cycles.
- jal (000011) -> JAL has pc_en=1, pc_src=10, reg_write=1, link=1. jr (000110) -> pc_src=11.
- Opcode 111111 -> illegal_op and instr_done pulse in DECODE, next state FETCH, no write strobes. FETCH with mem_ready low 2 cycles -> ir_write=0 until the ready cycle.
